// File: rtl/sample_iter_quad.sv
// Bounding-box sample iterator: walks one triangle's snapped box, SAMPS x-adjacent samples per cycle.
// Define ITER_PERF_EN to add saturating perfTri_RnnnnU / perfGrp_RnnnnU counters.
module sample_iter_quad #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                   validTri_R13H,
  input  logic [3:0]                             subSample_RnnnnU,
  output logic                                   halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S,
  output logic [SAMPS-1:0]                       validSamp_R14H
`ifdef ITER_PERF_EN
  ,
  output logic [31:0]                            perfTri_RnnnnU,
  output logic [31:0]                            perfGrp_RnnnnU
`endif
);

  typedef enum logic {WAIT_S, TEST_S} state_t;

  state_t state;

  logic signed [SIGFIG-1:0] ll_x, ur_x, ur_y;
  logic signed [SIGFIG-1:0] cur_x, cur_y, step;

  logic signed [SIGFIG-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y;
  logic                     box_empty, accept;

  logic signed [SIGFIG-1:0] slot_x [SAMPS];
  logic [SAMPS-1:0]         slot_ok;
  logic signed [SIGFIG-1:0] next_x, next_y;
  logic                     wrap, last_grp;

  function automatic logic signed [SIGFIG-1:0] step_of(input logic [3:0] sub);
    logic signed [SIGFIG-1:0] one;
    one = SIGFIG'(1);
    case (sub)
      4'b0100: step_of = one <<< (RADIX - 1);
      4'b0010: step_of = one <<< (RADIX - 2);
      4'b0001: step_of = one <<< (RADIX - 3);
      default: step_of = one <<< RADIX;
    endcase
  endfunction

  assign in_ll_x   = box_R13S[0][0];
  assign in_ll_y   = box_R13S[0][1];
  assign in_ur_x   = box_R13S[1][0];
  assign in_ur_y   = box_R13S[1][1];
  assign box_empty = (in_ll_x > in_ur_x) || (in_ll_y > in_ur_y);
  assign accept    = (state == WAIT_S) && validTri_R13H && !box_empty;

  assign halt_RnnnnL = (state == WAIT_S);

  // Sample positions of the current group and the raster-order advance decision.
  always_comb begin
    // NOTE: every combinational output is assigned on every path so no latch is inferred.
    slot_x[0] = cur_x;
    for (int k = 1; k < SAMPS; k++) slot_x[k] = slot_x[k-1] + step;
    slot_ok = '0;
    for (int k = 0; k < SAMPS; k++) slot_ok[k] = (slot_x[k] <= ur_x);
    next_x   = slot_x[SAMPS-1] + step;
    next_y   = cur_y + step;
    wrap     = (next_x > ur_x);
    last_grp = wrap && (next_y > ur_y);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the latched box and cursor are reset too; no partial triangle survives a reset.
      state          <= WAIT_S;
      ll_x           <= '0;
      ur_x           <= '0;
      ur_y           <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      step           <= '0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= '0;
    end else begin
      case (state)
        WAIT_S: begin
          validSamp_R14H <= '0;
          if (accept) begin
            tri_R14S   <= tri_R13S;
            color_R14U <= color_R13U;
            ll_x       <= in_ll_x;
            ur_x       <= in_ur_x;
            ur_y       <= in_ur_y;
            cur_x      <= in_ll_x;
            cur_y      <= in_ll_y;
            step       <= step_of(subSample_RnnnnU);
            state      <= TEST_S;
          end
          // An empty box is consumed here simply by not leaving WAIT_S.
        end
        TEST_S: begin
          for (int k = 0; k < SAMPS; k++) begin
            sample_R14S[0][k] <= slot_x[k];
            sample_R14S[1][k] <= cur_y;
          end
          validSamp_R14H <= slot_ok;
          if (wrap) begin
            cur_x <= ll_x;
            cur_y <= next_y;
          end else begin
            cur_x <= next_x;
          end
          if (last_grp) state <= WAIT_S;
        end
        default: state <= WAIT_S;
      endcase
    end
  end

`ifdef ITER_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfTri_RnnnnU <= '0;
      perfGrp_RnnnnU <= '0;
    end else begin
      if (accept && (perfTri_RnnnnU != '1)) perfTri_RnnnnU <= perfTri_RnnnnU + 32'd1;
      if ((state == TEST_S) && (perfGrp_RnnnnU != '1)) perfGrp_RnnnnU <= perfGrp_RnnnnU + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_iter_quad.sv
// Directed self-checking bench for sample_iter_quad (RADIX=10, SAMPS=4).
module tb_sample_iter_quad;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [2:0][2:0][23:0]    tri_R13S;
  logic [2:0][23:0]         color_R13U;
  logic [1:0][1:0][23:0]    box_R13S;
  logic                     validTri_R13H;
  logic [3:0]               subSample_RnnnnU;
  logic                     halt_RnnnnL;
  logic [2:0][2:0][23:0]    tri_R14S;
  logic [2:0][23:0]         color_R14U;
  logic [1:0][3:0][23:0]    sample_R14S;
  logic [3:0]               validSamp_R14H;
`ifdef ITER_PERF_EN
  logic [31:0]              perfTri_RnnnnU;
  logic [31:0]              perfGrp_RnnnnU;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  sample_iter_quad dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
`ifdef ITER_PERF_EN
    ,
    .perfTri_RnnnnU   (perfTri_RnnnnU),
    .perfGrp_RnnnnU   (perfGrp_RnnnnU)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input logic [23:0] seed, input logic [23:0] llx, input logic [23:0] lly,
                         input logic [23:0] urx, input logic [23:0] ury);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) tri_R13S[v][a] = seed + 24'(v * 16 + a);
    for (int c = 0; c < 3; c++) color_R13U[c] = seed + 24'h800 + 24'(c);
    box_R13S[0][0] = llx;
    box_R13S[0][1] = lly;
    box_R13S[1][0] = urx;
    box_R13S[1][1] = ury;
  endtask

  // Checks one emitted group: slot k at x0 + k*st, all at y, with per-slot valid mask v.
  task automatic check_grp(input string tag, input int x0, input int st, input int y,
                           input logic [3:0] v, input logic halt);
    check({tag, ".valid"}, 32'(validSamp_R14H), 32'(v));
    check({tag, ".halt"}, 32'(halt_RnnnnL), 32'(halt));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.x%0d", tag, k), 32'(sample_R14S[0][k]), 32'(x0 + k * st));
      check($sformatf("%s.y%0d", tag, k), 32'(sample_R14S[1][k]), 32'(y));
    end
  endtask

  task automatic check_idle(input string tag, input logic halt);
    check({tag, ".valid"}, 32'(validSamp_R14H), 32'h0);
    check({tag, ".halt"}, 32'(halt_RnnnnL), 32'(halt));
  endtask

  initial begin
    rst              = 1'b0;
    validTri_R13H    = 1'b0;
    subSample_RnnnnU = 4'b1000;
    set_tri(24'h0, 24'd0, 24'd0, 24'd0, 24'd0);

    // Reset state
    #3;
    check_idle("rst", 1'b1);
    check("rst.tri", 32'(tri_R14S[2][2]), 32'h0);
    check("rst.color", 32'(color_R14U[1]), 32'h0);
    check("rst.samp", 32'(sample_R14S[1][3]), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_idle("post_rst", 1'b1);

    // Case 1: (0,0)-(3072,1024), two full groups, halt low exactly two cycles
    set_tri(24'h1000, 24'd0, 24'd0, 24'd3072, 24'd1024);
    validTri_R13H = 1'b1;
    tick();
    validTri_R13H = 1'b0;
    check_idle("c1.acc", 1'b0);
    check("c1.tri00", 32'(tri_R14S[0][0]), 32'h1000);
    check("c1.tri22", 32'(tri_R14S[2][2]), 32'h1022);
    check("c1.col2", 32'(color_R14U[2]), 32'h1802);
    tick();
    check_grp("c1.g0", 0, 1024, 0, 4'b1111, 1'b0);
    tick();
    check_grp("c1.g1", 0, 1024, 1024, 4'b1111, 1'b1);
    tick();
    check_idle("c1.done", 1'b1);
    check("c1.hold_y", 32'(sample_R14S[1][0]), 32'd1024);
    check("c1.hold_x", 32'(sample_R14S[0][3]), 32'd3072);

    // Case 2: (0,0)-(2048,0), one group with the last slot past URx
    set_tri(24'h2000, 24'd0, 24'd0, 24'd2048, 24'd0);
    validTri_R13H = 1'b1;
    tick();
    validTri_R13H = 1'b0;
    check_idle("c2.acc", 1'b0);
    tick();
    check_grp("c2.g0", 0, 1024, 0, 4'b0111, 1'b1);
    tick();
    check_idle("c2.done", 1'b1);

    // Case 3: empty box is dropped, nothing latched
    set_tri(24'h3000, 24'd1024, 24'd0, 24'd0, 24'd0);
    validTri_R13H = 1'b1;
    tick();
    validTri_R13H = 1'b0;
    check_idle("c3.a", 1'b1);
    check("c3.tri", 32'(tri_R14S[0][0]), 32'h2000);
    tick();
    check_idle("c3.b", 1'b1);

    // Case 4: step 128, (0,0)-(896,128), four groups; subSample change mid-triangle ignored
    subSample_RnnnnU = 4'b0001;
    set_tri(24'h4000, 24'd0, 24'd0, 24'd896, 24'd128);
    validTri_R13H = 1'b1;
    tick();
    validTri_R13H    = 1'b0;
    subSample_RnnnnU = 4'b1000;
    check_idle("c4.acc", 1'b0);
    tick();
    check_grp("c4.g0", 0, 128, 0, 4'b1111, 1'b0);
    tick();
    check_grp("c4.g1", 512, 128, 0, 4'b1111, 1'b0);
    tick();
    check_grp("c4.g2", 0, 128, 128, 4'b1111, 1'b0);
    tick();
    check_grp("c4.g3", 512, 128, 128, 4'b1111, 1'b1);
    tick();
    check_idle("c4.done", 1'b1);

    // Case 5: asynchronous reset in the middle of the case-4 triangle
    subSample_RnnnnU = 4'b0001;
    validTri_R13H    = 1'b1;
    tick();
    validTri_R13H = 1'b0;
    tick();
    check_grp("c5.g0", 0, 128, 0, 4'b1111, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_idle("c5.async", 1'b1);
    check("c5.samp", 32'(sample_R14S[0][1]), 32'h0);
    check("c5.tri", 32'(tri_R14S[0][0]), 32'h0);
    tick();
    rst              = 1'b1;
    subSample_RnnnnU = 4'b1000;
    set_tri(24'h5000, 24'd2048, 24'd1024, 24'd4096, 24'd1024);
    validTri_R13H = 1'b1;
    tick();
    validTri_R13H = 1'b0;
    check_idle("c5.acc", 1'b0);
    tick();
    check_grp("c5.new", 2048, 1024, 1024, 4'b0111, 1'b1);
    tick();
    check_idle("c5.done", 1'b1);

    // Case 6: validTri held high across two one-group boxes, from a clean reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_tri(24'h6000, 24'd0, 24'd0, 24'd1024, 24'd0);
    validTri_R13H = 1'b1;
    tick();
    set_tri(24'h7000, 24'd0, 24'd2048, 24'd0, 24'd2048);
    check_idle("c6.accA", 1'b0);
    tick();
    check_grp("c6.gA", 0, 1024, 0, 4'b0011, 1'b1);
    tick();
    validTri_R13H = 1'b0;
    check_idle("c6.accB", 1'b0);
    check("c6.triB", 32'(tri_R14S[0][0]), 32'h7000);
    tick();
    check_grp("c6.gB", 0, 1024, 2048, 4'b0001, 1'b1);
    tick();
    check_idle("c6.done", 1'b1);
`ifdef ITER_PERF_EN
    check("c6.perfTri", perfTri_RnnnnU, 32'd2);
    check("c6.perfGrp", perfGrp_RnnnnU, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
